// File: rtl/sound_scheduler.sv
// Fixed-priority scheduler for one shared tone serializer: grant, timed note, silence gap.
// Optional build macro SOUND_SCHED_PREEMPT_EN lets a higher-priority request abort the current note.
module sound_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SYS_FREQ  = 100000,
  parameter int unsigned TICK_FREQ = 1000,
  parameter int unsigned FREQ_BITS = 10,
  parameter int unsigned DUR_BITS  = 8,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FREQ_BITS-1:0]  req_freq,
  input  logic [NUM_REQ*DUR_BITS-1:0]   req_dur,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [FREQ_BITS-1:0]          tone_freq,
  output logic                          tone_en,
  output logic                          done,
  output logic                          busy
);

  localparam int unsigned TICK_DIV = SYS_FREQ / TICK_FREQ;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  localparam state_t END_STATE = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [DUR_BITS-1:0]  dur_q, dur_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [FREQ_BITS-1:0] freq_q, freq_d;
  logic                 tone_en_q, tone_en_d;
  logic                 done_q, done_d;

  logic [NUM_REQ-1:0]   sel_oh;
  logic [FREQ_BITS-1:0] sel_freq;
  logic [DUR_BITS-1:0]  sel_dur;
  logic                 presc_wrap;

  // Isolate the lowest set request bit; index 0 wins.
  assign sel_oh = req & (~req + 1'b1);

  always_comb begin
    sel_freq = '0;
    sel_dur  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_freq = req_freq[i*FREQ_BITS +: FREQ_BITS];
        sel_dur  = req_dur[i*DUR_BITS +: DUR_BITS];
      end
    end
  end

  assign presc_wrap = (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    ack_d     = '0;
    done_d    = 1'b0;
    grant_d   = grant_q;
    freq_d    = freq_q;
    tone_en_d = tone_en_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          ack_d   = sel_oh;
          freq_d  = sel_freq;
          dur_d   = sel_dur;
          presc_d = '0;
          gap_d   = '0;
          if (sel_dur == '0) begin
            // Zero-length request: acknowledged and finished on the same edge.
            done_d    = 1'b1;
            state_d   = END_STATE;
            grant_d   = '0;
            tone_en_d = 1'b0;
          end else begin
            state_d   = S_PLAY;
            grant_d   = sel_oh;
            tone_en_d = (sel_freq != '0);
          end
        end
      end
      S_PLAY: begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (presc_wrap) begin
          dur_d = dur_q - 1'b1;
          if (dur_q == DUR_BITS'(1)) begin
            state_d   = END_STATE;
            grant_d   = '0;
            tone_en_d = 1'b0;
            done_d    = 1'b1;
          end
        end
`ifdef SOUND_SCHED_PREEMPT_EN
        // grant_q - 1 masks every index below the current one-hot grant.
        if (|(req & (grant_q - 1'b1))) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          tone_en_d = 1'b0;
          done_d    = 1'b1;
          presc_d   = '0;
          dur_d     = '0;
        end
`endif
      end
      S_GAP: begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (presc_wrap) begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      freq_q    <= '0;
      tone_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      freq_q    <= freq_d;
      tone_en_q <= tone_en_d;
      done_q    <= done_d;
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign tone_freq = freq_q;
  assign tone_en   = tone_en_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler (TICK_DIV=4, GAP_TICKS=2); honours SOUND_SCHED_PREEMPT_EN.
module tb_sound_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] req_freq;
  logic [31:0] req_dur;
  logic [3:0]  ack, grant;
  logic [9:0]  tone_freq;
  logic        tone_en, done, busy;

  always #5 clk = ~clk;

  sound_scheduler #(
    .NUM_REQ(4), .SYS_FREQ(4000), .TICK_FREQ(1000),
    .FREQ_BITS(10), .DUR_BITS(8), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_freq(req_freq), .req_dur(req_dur),
    .ack(ack), .grant(grant), .tone_freq(tone_freq), .tone_en(tone_en),
    .done(done), .busy(busy)
  );

  typedef struct {
    logic [3:0] oh;
    logic [9:0] freq;
    logic [7:0] dur;
    int         gnt;
    int         ton;
    int         gap;
    int         idle;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active, gap_trk;
  int   gnt_cnt, ton_cnt, gap_cnt, idle_cnt, acks_seen;
  int   checks, errors;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0; gap_trk = 1'b0; idle_cnt = 0;
        continue;
      end
      if (ack != 4'd0) begin
        acks_seen++;
        if (q.size() == 0) chk("unexpected_ack", ack, 0);
        else begin
          cur = q.pop_front();
          active = 1'b1;
          chk("ack", ack, cur.oh);
          chk("grant_at_ack", grant, (cur.dur != 0) ? cur.oh : 4'd0);
          chk("tone_freq_at_ack", tone_freq, cur.freq);
          chk("tone_en_at_ack", tone_en, (cur.dur != 0 && cur.freq != 0));
          chk("done_with_ack", done, (cur.dur == 0));
          if (cur.idle >= 0) chk("idle_cycles", idle_cnt, cur.idle);
          gnt_cnt = 0; ton_cnt = 0;
        end
      end
      if (active) begin
        if (grant != 4'd0) gnt_cnt++;
        if (tone_en) ton_cnt++;
      end else if (grant != 4'd0 || tone_en) chk("stray_output", 1, 0);
      if (done) begin
        if (!active) chk("unexpected_done", 1, 0);
        else begin
          chk("grant_cycles", gnt_cnt, cur.gnt);
          chk("tone_cycles", ton_cnt, cur.ton);
          chk("tone_freq_held", tone_freq, cur.freq);
          active = 1'b0; gap_trk = 1'b1; gap_cnt = 0;
        end
      end
      if (gap_trk) begin
        if (busy) gap_cnt++;
        else begin
          chk("gap_cycles", gap_cnt, cur.gap);
          gap_trk = 1'b0;
        end
      end
      if (busy) idle_cnt = 0; else idle_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input int fr, input int du);
    req_freq[idx*10 +: 10] = 10'(fr);
    req_dur[idx*8 +: 8]    = 8'(du);
  endtask

  task automatic push(input int idx, input int fr, input int du, input int idle);
    exp_t e;
    e.oh = 4'(1 << idx); e.freq = 10'(fr); e.dur = 8'(du);
    e.gnt = du * 4; e.ton = (fr != 0) ? du * 4 : 0; e.gap = 8; e.idle = idle;
    q.push_back(e);
  endtask

  task automatic wait_acks(input int target);
    for (int i = 0; i < 200 && acks_seen < target; i++) tick();
    if (acks_seen < target) chk("ack_timeout", acks_seen, target);
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      if (q.size() == 0 && !active && !gap_trk && !busy) break;
      tick();
    end
    if (n == 300) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_tone_freq"}, tone_freq, 0);
    chk({tag, "_tone_en"}, tone_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    checks = 0; errors = 0; acks_seen = 0;
    active = 1'b0; gap_trk = 1'b0; idle_cnt = 0;
    reset = 1'b1; req = '0; req_freq = '0; req_dur = '0;
    fork monitor(); join_none
    repeat (2) tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();

    // Single request
    set_src(1, 554, 3); push(1, 554, 3, -1);
    req[1] = 1'b1; wait_acks(acks_seen + 1); req[1] = 1'b0;
    wait_idle();

    // Simultaneous requests: index 1 first, index 3 after the gap
    set_src(1, 830, 2); set_src(3, 554, 2);
    push(1, 830, 2, -1); push(3, 554, 2, 1);
    req = 4'b1010;
    wait_acks(acks_seen + 1); req[1] = 1'b0;
    wait_acks(acks_seen + 1); req[3] = 1'b0;
    wait_idle();

    // Zero duration and timed rest
    set_src(2, 700, 0); push(2, 700, 0, -1);
    req[2] = 1'b1; wait_acks(acks_seen + 1); req[2] = 1'b0;
    wait_idle();
    set_src(0, 0, 2); push(0, 0, 2, -1);
    req[0] = 1'b1; wait_acks(acks_seen + 1); req[0] = 1'b0;
    wait_idle();

    // Held request repeats; inputs changed during the last note are ignored
    set_src(0, 415, 1);
    push(0, 415, 1, -1); push(0, 415, 1, 1); push(0, 415, 1, 1);
    req[0] = 1'b1;
    wait_acks(acks_seen + 3);
    req[0] = 1'b0; set_src(0, 700, 9);
    wait_idle();

    // Reset mid-note
    set_src(2, 600, 3); push(2, 600, 3, -1);
    req[2] = 1'b1; wait_acks(acks_seen + 1); req[2] = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1 check_cleared("async_reset");
    tick();
    reset = 1'b0;
    tick();
    set_src(3, 523, 1); push(3, 523, 1, -1);
    req[3] = 1'b1; wait_acks(acks_seen + 1); req[3] = 1'b0;
    wait_idle();

    // Higher-priority request during a note
    set_src(2, 494, 3); set_src(0, 830, 1);
`ifdef SOUND_SCHED_PREEMPT_EN
    e.oh = 4'b0100; e.freq = 10'd494; e.dur = 8'd3;
    e.gnt = 6; e.ton = 6; e.gap = 0; e.idle = -1;
    q.push_back(e);
`else
    push(2, 494, 3, -1);
`endif
    push(0, 830, 1, 1);
    req[2] = 1'b1; wait_acks(acks_seen + 1); req[2] = 1'b0;
    repeat (5) tick();
    req[0] = 1'b1;
    wait_acks(acks_seen + 1); req[0] = 1'b0;
    wait_idle();

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
